// File: rtl/cpu_ram_responder.sv
// -----------------------------------------------------------------------------
// cpu_ram_responder
//
// Dual-port synchronous word memory serving the CPU instruction-fetch port
// (port 1) and load/store data port (port 2), plus a host loader that shares
// the port 1 write path. After reset the array is zero-filled by a sweep, then
// both ports are serviced with a fixed one-cycle, read-first read latency.
//
// State table:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | sweeping clr_addr 0..DEPTH-1, writing 0; all requests ignored
//   ST_RUN   | sweep done; CPU ports and loader serviced once mem_ready=1
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   addr1/w_en1/wdata1       port 1 (fetch) address, write enable, write data
//   rdata1                   port 1 registered read data
//   addr2/w_en2/wdata2       port 2 (load/store) address, write enable, data
//   rdata2                   port 2 registered read data
//   load_valid/addr/data     loader write request
//   load_ready               loader request accepted when load_valid is high
//   mem_ready                high while CPU ports are being serviced
// -----------------------------------------------------------------------------
module cpu_ram_responder #(
   parameter int ADDR_W         = 11,
   parameter int DATA_W         = 32,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              w_en1,
   input  logic [DATA_W-1:0] wdata1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [ADDR_W-1:0] addr2,
   input  logic              w_en2,
   input  logic [DATA_W-1:0] wdata2,
   output logic [DATA_W-1:0] rdata2,
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              mem_ready
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
   logic              clr_we;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_data;
   logic              p1_keep;
   logic              p2_we;

   // ---------------------------------------------------------------------------
   // Sequencer state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if (CLEAR_ON_RESET) begin
            state <= ST_CLEAR;
         end else begin
            state <= ST_RUN;
         end
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state: sweep one word per cycle, leave CLEAR after the last address.
   // The counter wraps back to 0 naturally on that final increment.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      clr_we       = 1'b0;
      case (state)
         ST_CLEAR: begin
            // rst gates the write so a held reset does not keep hitting word 0
            clr_we       = ~rst;
            clr_addr_nxt = clr_addr + 1'b1;
            if (clr_addr == {ADDR_W{1'b1}}) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            state_nxt = ST_RUN;
         end
         default: begin
            state_nxt    = ST_CLEAR;
            clr_addr_nxt = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // mem_ready trails the RUN state by one edge. This gives the sweep its full
   // DEPTH-cycle duration and, with CLEAR_ON_RESET=0, raises mem_ready on the
   // first edge after reset.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_ready <= 1'b0;
      end else begin
         mem_ready <= (state == ST_RUN);
      end
   end

   assign load_ready = mem_ready & ~w_en1;

   // ---------------------------------------------------------------------------
   // Write path. Port 1 carries, in priority order, the clear sweep, the CPU
   // port 1 store, or the loader. Port 2 beats port 1 on an address collision.
   // ---------------------------------------------------------------------------
   always_comb begin
      p1_we   = 1'b0;
      p1_addr = addr1;
      p1_data = wdata1;
      if (clr_we) begin
         p1_we   = 1'b1;
         p1_addr = clr_addr;
         p1_data = '0;
      end else if (mem_ready) begin
         if (w_en1) begin
            p1_we   = 1'b1;
            p1_addr = addr1;
            p1_data = wdata1;
         end else if (load_valid) begin
            p1_we   = 1'b1;
            p1_addr = load_addr;
            p1_data = load_data;
         end
      end
   end

   assign p2_we   = mem_ready & w_en2;
   assign p1_keep = p1_we & ~(p2_we & (p1_addr == addr2));

   always_ff @(posedge clk) begin
      if (p1_keep) begin
         mem[p1_addr] <= p1_data;
      end
      if (p2_we) begin
         mem[addr2] <= wdata2;
      end
   end

   // ---------------------------------------------------------------------------
   // Registered read-first outputs; forced to 0 whenever ports are not serviced.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata1 <= '0;
         rdata2 <= '0;
      end else if (mem_ready) begin
         rdata1 <= mem[addr1];
         rdata2 <= mem[addr2];
      end else begin
         rdata1 <= '0;
         rdata2 <= '0;
      end
   end

endmodule

// File: tb/tb_cpu_ram_responder.sv
module tb_cpu_ram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] addr1, addr2, load_addr;
   logic        w_en1, w_en2, load_valid;
   logic [31:0] wdata1, wdata2, load_data;
   logic [31:0] rdata1, rdata2;
   logic        load_ready, mem_ready;

   int vectors    = 0;
   int miscompares = 0;

   logic [31:0] model [2048];

   cpu_ram_responder dut (
      .clk        (clk),
      .rst        (rst),
      .addr1      (addr1),
      .w_en1      (w_en1),
      .wdata1     (wdata1),
      .rdata1     (rdata1),
      .addr2      (addr2),
      .w_en2      (w_en2),
      .wdata2     (wdata2),
      .rdata2     (rdata2),
      .load_valid (load_valid),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .load_ready (load_ready),
      .mem_ready  (mem_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      addr1 = '0; w_en1 = 1'b0; wdata1 = '0;
      addr2 = '0; w_en2 = 1'b0; wdata2 = '0;
      load_valid = 1'b0; load_addr = '0; load_data = '0;
   endtask

   task automatic model_zero();
      for (int i = 0; i < 2048; i++) model[i] = 32'h0;
   endtask

   // One RUN cycle: drive inputs, check load_ready before the edge, then check
   // read data after the edge against the memory contents seen before it.
   task automatic apply(input logic [10:0] a1, input logic we1, input logic [31:0] d1,
                        input logic [10:0] a2, input logic we2, input logic [31:0] d2,
                        input logic lv, input logic [10:0] la, input logic [31:0] ld);
      logic [31:0] exp_r1, exp_r2;
      logic        p1;
      logic [10:0] pa;
      logic [31:0] pd;
      addr1 = a1; w_en1 = we1; wdata1 = d1;
      addr2 = a2; w_en2 = we2; wdata2 = d2;
      load_valid = lv; load_addr = la; load_data = ld;
      exp_r1 = model[a1];
      exp_r2 = model[a2];
      @(negedge clk);
      chk("load_ready", {31'b0, load_ready}, {31'b0, ~we1});
      @(posedge clk); #1;
      p1 = we1 | lv;
      pa = we1 ? a1 : la;
      pd = we1 ? d1 : ld;
      if (p1 && !(we2 && pa == a2)) model[pa] = pd;
      if (we2) model[a2] = d2;
      chk("rdata1", rdata1, exp_r1);
      chk("rdata2", rdata2, exp_r2);
   endtask

   task automatic rd(input logic [10:0] a1, input logic [10:0] a2);
      apply(a1, 1'b0, 32'h0, a2, 1'b0, 32'h0, 1'b0, 11'h0, 32'h0);
   endtask

   // Called just after rst release; counts edges after the first one until
   // mem_ready is seen high. Optionally pokes stale data and probes CLEAR.
   task automatic wait_ready(input bit backdoor, output int n);
      n = 0;
      @(posedge clk); #1;
      while (!mem_ready && n < 5000) begin
         @(posedge clk); #1;
         n++;
         if (n == 10 && backdoor) dut.mem[1500] = 32'h12345678;
         if (n == 100) begin
            chk("clear_load_ready", {31'b0, load_ready}, 32'h0);
            chk("clear_rdata1", rdata1, 32'h0);
            chk("clear_rdata2", rdata2, 32'h0);
         end
      end
   endtask

   initial begin
      int n;
      logic [10:0] ra1, ra2, rla;
      rst = 1'b1;
      drive_idle();
      model_zero();
      #1;
      chk("rst_rdata1", rdata1, 32'h0);
      chk("rst_rdata2", rdata2, 32'h0);
      chk("rst_mem_ready", {31'b0, mem_ready}, 32'h0);
      chk("rst_load_ready", {31'b0, load_ready}, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      // requests during CLEAR must be ignored
      load_valid = 1'b1; load_addr = 11'd5; load_data = 32'hBADBAD01;
      w_en2 = 1'b1; addr2 = 11'd6; wdata2 = 32'hBADBAD02;
      addr1 = 11'd7;
      rst = 1'b0;
      wait_ready(1'b0, n);
      chk("clear_cycles", n, 32'd2048);
      drive_idle();

      rd(11'd0, 11'd1023);
      rd(11'd2047, 11'd0);
      rd(11'd1023, 11'd2047);
      rd(11'd5, 11'd6);
      chk("clear_ignored_load", rdata1, 32'h0);
      chk("clear_ignored_store", rdata2, 32'h0);

      // loader then fetch
      apply(11'h0, 1'b0, 32'h0, 11'h0, 1'b0, 32'h0, 1'b1, 11'h010, 32'hE3A01005);
      apply(11'h0, 1'b0, 32'h0, 11'h0, 1'b0, 32'h0, 1'b1, 11'h7FF, 32'hDEADBEEF);
      rd(11'h010, 11'h7FF);
      chk("fetch_r1", rdata1, 32'hE3A01005);
      chk("fetch_r2", rdata2, 32'hDEADBEEF);

      // read-first
      apply(11'h0, 1'b0, 32'h0, 11'h0, 1'b0, 32'h0, 1'b1, 11'h020, 32'h11111111);
      apply(11'h0, 1'b0, 32'h0, 11'h020, 1'b1, 32'h22222222, 1'b0, 11'h0, 32'h0);
      chk("read_first_old", rdata2, 32'h11111111);
      rd(11'h0, 11'h020);
      chk("read_first_new", rdata2, 32'h22222222);

      // write collision
      apply(11'h040, 1'b1, 32'hAAAA0000, 11'h040, 1'b1, 32'h5555FFFF, 1'b0, 11'h0, 32'h0);
      rd(11'h040, 11'h040);
      chk("collision_r1", rdata1, 32'h5555FFFF);
      chk("collision_r2", rdata2, 32'h5555FFFF);

      // loader backpressure: three stalled cycles, then one accepted write
      for (int i = 0; i < 3; i++)
         apply(11'h081, 1'b1, 32'h00000100 + i, 11'h0, 1'b0, 32'h0, 1'b1, 11'h080, 32'hCAFEF00D);
      rd(11'h080, 11'h081);
      chk("bp_not_written", rdata1, 32'h0);
      apply(11'h0, 1'b0, 32'h0, 11'h0, 1'b0, 32'h0, 1'b1, 11'h080, 32'hCAFEF00D);
      rd(11'h080, 11'h081);
      chk("bp_written", rdata1, 32'hCAFEF00D);
      chk("bp_p1_store", rdata2, 32'h00000102);

      // randomized traffic over a narrow window plus occasional full-range hits
      for (int i = 0; i < 400; i++) begin
         ra1 = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
         ra2 = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
         rla = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
         apply(ra1, 1'($urandom_range(0, 1)), $urandom,
               ra2, 1'($urandom_range(0, 1)), $urandom,
               1'($urandom_range(0, 1)), rla, $urandom);
      end

      // asynchronous reset in RUN with non-zero read data
      rd(11'h010, 11'h7FF);
      chk("pre_rst_r1", rdata1, model[11'h010]);
      drive_idle();
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_r1", rdata1, 32'h0);
      chk("async_rst_r2", rdata2, 32'h0);
      chk("async_rst_ready", {31'b0, mem_ready}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // reset again at sweep cycle 1000, then plant stale data ahead of the sweep
      repeat (1000) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_sweep_r1", rdata1, 32'h0);
      chk("mid_sweep_ready", {31'b0, mem_ready}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      wait_ready(1'b1, n);
      chk("resweep_cycles", n, 32'd2048);
      model_zero();
      rd(11'd1500, 11'h010);
      chk("stale_cleared", rdata1, 32'h0);
      rd(11'h7FF, 11'd1500);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
